// File: rtl/issue_stage.sv
// issue_stage: decoupling FIFO plus register scoreboard between decode and execute.
//
// Decoded instructions are queued in order in a DEPTH-entry FIFO. The head
// instruction is offered to execute only when none of its registers is
// marked busy. An accepted issue marks the head's rd busy, and a writeback
// clears that bit again.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   flush                 drop every buffered instruction (branch redirect)
//   inValid / inReady     decode-side handshake
//   inPc..inIsBranch      decoded instruction fields
//   outValid / outReady   execute-side handshake (outValid never looks at outReady)
//   outPc..outIsBranch    fields of the FIFO head
//   wbValid, wbRd         writeback that clears a busy bit
//   busyMask              scoreboard, bit i = register i has a write pending
//   count                 FIFO occupancy
module issue_stage #(
    parameter int XLEN       = 32,
    parameter int PCLEN      = 10,
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [PCLEN-1:0]      inPc,
    input  logic [4:0]            inRd,
    input  logic [4:0]            inRs1,
    input  logic [4:0]            inRs2,
    input  logic [XLEN-1:0]       inImm,
    input  logic [11:0]           inCode,
    input  logic                  inIsLoad,
    input  logic                  inIsBranch,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [PCLEN-1:0]      outPc,
    output logic [4:0]            outRd,
    output logic [4:0]            outRs1,
    output logic [4:0]            outRs2,
    output logic [XLEN-1:0]       outImm,
    output logic [11:0]           outCode,
    output logic                  outIsLoad,
    output logic                  outIsBranch,
    input  logic                  wbValid,
    input  logic [4:0]            wbRd,
    output logic [31:0]           busyMask,
    output logic [DEPTH_LOG2:0]   count
);

    typedef struct packed {
        logic [PCLEN-1:0] pc;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [XLEN-1:0]  imm;
        logic [11:0]      code;
        logic             is_load;
        logic             is_branch;
    } entry_t;

    localparam logic [DEPTH_LOG2:0]   FULL    = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);

    entry_t                mem [DEPTH];
    entry_t                in_entry;
    entry_t                head;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic [31:0]           busy;
    logic [31:0]           busy_nxt;
    logic                  hazard;
    logic                  push;
    logic                  pop;
    logic                  wr_en;

    assign in_entry = '{pc: inPc, rd: inRd, rs1: inRs1, rs2: inRs2, imm: inImm,
                        code: inCode, is_load: inIsLoad, is_branch: inIsBranch};
    assign head     = mem[rd_ptr];

    assign outPc       = head.pc;
    assign outRd       = head.rd;
    assign outRs1      = head.rs1;
    assign outRs2      = head.rs2;
    assign outImm      = head.imm;
    assign outCode     = head.code;
    assign outIsLoad   = head.is_load;
    assign outIsBranch = head.is_branch;

    // Only the registered scoreboard is consulted, so a writeback unblocks
    // the head one cycle later and there is no wb -> issue combinational path.
    assign hazard = (head.rs1 != 5'd0 && busy[head.rs1]) ||
                    (head.rs2 != 5'd0 && busy[head.rs2]) ||
                    (head.rd  != 5'd0 && busy[head.rd]);

    assign inReady  = (cnt != FULL);   // a full FIFO refuses even if popping
    assign outValid = (cnt != '0) && !hazard;
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady;
    assign wr_en    = push && !flush;  // flush discards a same-cycle push

    assign busyMask = busy;
    assign count    = cnt;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Set after clear so an issue wins over a writeback of the same register.
    // A pop during flush still counts: that instruction did leave for execute.
    always_comb begin
        busy_nxt = busy;
        if (wbValid && wbRd != 5'd0) busy_nxt[wbRd] = 1'b0;
        if (pop && head.rd != 5'd0)  busy_nxt[head.rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end

endmodule
